// File: rtl/font_arb_pkg.sv
// Shared types and defaults for the font ROM arbiter: address/data widths,
// return-tag encoding and secondary-requester FSM states.
package font_arb_pkg;

  localparam int FONT_ADDR_W   = 11;
  localparam int FONT_DATA_W   = 8;
  localparam int FONT_MAX_WAIT = 15;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_VID  = 2'd1,
    TAG_SEC  = 2'd2
  } tag_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PEND = 2'd1,
    S_RD   = 2'd2,
    S_ACK  = 2'd3
  } state_t;

endpackage

// File: rtl/font_arb_tag_pipe.sv
// Delay line that carries the owner tag of each ROM read until its data is
// ready to be steered; depth matches the read-data latency.
module font_arb_tag_pipe
  import font_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t stage [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= TAG_NONE;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/font_rom_arbiter.sv
// Two-port arbiter in front of the single-port font ROM; video always wins.
// Build option FONT_ARB_OUT_REG_EN adds an output data register (latency 2).
//
// state  | meaning
// S_IDLE | no secondary transaction; a sec_req is granted now or parked
// S_PEND | secondary request waiting behind video, wait_cnt counting
// S_RD   | secondary read in flight, leaves when sec_ack pulses
// S_ACK  | one-cycle turnaround, no secondary grant
module font_rom_arbiter
  import font_arb_pkg::*;
#(
  parameter int ADDR_W   = FONT_ADDR_W,
  parameter int DATA_W   = FONT_DATA_W,
  parameter int MAX_WAIT = FONT_MAX_WAIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_data,
  input  logic              sec_req,
  input  logic [ADDR_W-1:0] sec_addr,
  output logic              sec_ack,
  output logic [DATA_W-1:0] sec_data,
  output logic              sec_starved,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

`ifdef FONT_ARB_OUT_REG_EN
  localparam int PIPE_DEPTH = 2;
`else
  localparam int PIPE_DEPTH = 1;
`endif

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] vid_hold;
  logic [DATA_W-1:0] sec_hold;
  logic [DATA_W-1:0] data_src;
  logic              vid_grant;
  logic              sec_grant;
  tag_t              tag_in;
  tag_t              tag_out;

  always_comb begin
    vid_grant = !reset && vid_req;
    sec_grant = !reset && !vid_req &&
                ((state == S_IDLE && sec_req) || state == S_PEND);
    tag_in    = TAG_NONE;
    rom_addr  = last_addr;
    if (reset) begin
      rom_addr = '0;
    end else if (vid_grant) begin
      tag_in   = TAG_VID;
      rom_addr = vid_addr;
    end else if (sec_grant) begin
      tag_in   = TAG_SEC;
      rom_addr = sec_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)          last_addr <= '0;
    else if (vid_grant) last_addr <= vid_addr;
    else if (sec_grant) last_addr <= sec_addr;
  end

  font_arb_tag_pipe #(.DEPTH(PIPE_DEPTH)) u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (sec_req) begin
          if (vid_req) begin
            state    <= S_PEND;
            wait_cnt <= WAIT_W'(1);  // the request already lost this cycle
          end else begin
            state    <= S_RD;
          end
        end
        S_PEND: if (!vid_req) begin
          state    <= S_RD;
          wait_cnt <= '0;
        end else if (wait_cnt < WAIT_W'(MAX_WAIT)) begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
        end
        S_RD:    if (sec_ack) state <= S_ACK;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign sec_starved = (state == S_PEND) && (wait_cnt >= WAIT_W'(MAX_WAIT));

`ifdef FONT_ARB_OUT_REG_EN
  logic [DATA_W-1:0] rom_data_q;

  always_ff @(posedge clk) begin
    if (reset) rom_data_q <= '0;
    else       rom_data_q <= rom_data;
  end

  assign data_src = rom_data_q;
`else
  assign data_src = rom_data;
`endif

  // Valid strobes are masked during reset so in-flight reads never surface.
  always_comb begin
    vid_valid = !reset && (tag_out == TAG_VID);
    sec_ack   = !reset && (tag_out == TAG_SEC);
    vid_data  = vid_valid ? data_src : vid_hold;
    sec_data  = sec_ack   ? data_src : sec_hold;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vid_hold <= '0;
      sec_hold <= '0;
    end else begin
      if (vid_valid) vid_hold <= data_src;
      if (sec_ack)   sec_hold <= data_src;
    end
  end

endmodule
